// File: rtl/button_cmd_scheduler_if.sv
// Button levels in, one shared command valid/ready port out, plus drop/busy status.
interface button_cmd_scheduler_if #(
    parameter int N_BTN = 4
);
    localparam int ID_W = $clog2(N_BTN);

    logic [N_BTN-1:0] btn_level;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ID_W-1:0]  cmd_id;
    logic             cmd_repeat;
    logic             drop;
    logic             busy;

    modport master (
        input  btn_level, cmd_ready,
        output cmd_valid, cmd_id, cmd_repeat, drop, busy
    );

    modport slave (
        output btn_level, cmd_ready,
        input  cmd_valid, cmd_id, cmd_repeat, drop, busy
    );
endinterface

// File: rtl/button_cmd_scheduler.sv
// Press/hold-to-repeat event generator per button, round-robin onto one command port.
// Latency: level rise before edge k -> pending at k -> cmd_valid at k+1 (port free).
// Backpressure: command held while !cmd_ready; a second event on a pending button drops.
module button_cmd_scheduler #(
    parameter int N_BTN        = 4,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                   fclk,
    input  logic                   reset,
    button_cmd_scheduler_if.master sched
);
    localparam int ID_W = $clog2(N_BTN);
    localparam logic [7:0]    DELAY_M1 = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0]    RATE_M1  = 8'(REPEAT_RATE - 1);
    localparam logic [ID_W:0] NB       = (ID_W + 1)'(N_BTN);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_BTN - 1);

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [7:0]       cnt_q   [N_BTN];
    logic [7:0]       cnt_d   [N_BTN];
    logic [N_BTN-1:0] lvl, lvl_q, rise;
    logic [N_BTN-1:0] ev, ev_rpt;
    logic [N_BTN-1:0] pend_q, pend_d, ptype_q, ptype_d, gnt;
    logic [ID_W-1:0]  rr_ptr, gnt_id;
    logic             gnt_any, load, drop_d;

    assign lvl  = sched.btn_level;
    assign rise = lvl & ~lvl_q;
    assign load = !sched.cmd_valid || sched.cmd_ready;
    assign sched.busy = (|pend_q) || sched.cmd_valid;

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            lvl_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            lvl_q <= lvl;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Release wins over the terminal count: the low-level test comes first.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: if (rise[i]) begin
                    state_d[i] = HOLD;
                    cnt_d[i]   = '0;
                end
                HOLD: if (!lvl[i]) begin
                    state_d[i] = IDLE;
                end else if (cnt_q[i] == DELAY_M1) begin
                    state_d[i] = RPT;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
                RPT: if (!lvl[i]) begin
                    state_d[i] = IDLE;
                end else if (cnt_q[i] == RATE_M1) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        ev     = '0;
        ev_rpt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (state_q[i])
                IDLE: ev[i] = rise[i];
                HOLD: if (lvl[i] && cnt_q[i] == DELAY_M1) begin
                    ev[i]     = 1'b1;
                    ev_rpt[i] = 1'b1;
                end
                RPT: if (lvl[i] && cnt_q[i] == RATE_M1) begin
                    ev[i]     = 1'b1;
                    ev_rpt[i] = 1'b1;
                end
                default: ev[i] = 1'b0;
            endcase
        end
    end

    // Scan downwards so the entry closest to rr_ptr is the last (winning) write.
    always_comb begin
        logic [ID_W:0] idx;
        gnt_any = 1'b0;
        gnt_id  = rr_ptr;
        idx     = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (idx >= NB) idx = idx - NB;
            if (pend_q[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
        gnt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            gnt[i] = load && gnt_any && (gnt_id == ID_W'(i));
        end
    end

    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        drop_d  = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (ev[i] && pend_q[i] && !gnt[i]) begin
                drop_d = 1'b1;
            end else if (ev[i]) begin
                pend_d[i]  = 1'b1;
                ptype_d[i] = ev_rpt[i];
            end else if (gnt[i]) begin
                pend_d[i] = 1'b0;
            end else if (!lvl[i] && ptype_q[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            pend_q           <= '0;
            ptype_q          <= '0;
            rr_ptr           <= '0;
            sched.cmd_valid  <= 1'b0;
            sched.cmd_id     <= '0;
            sched.cmd_repeat <= 1'b0;
            sched.drop       <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            ptype_q    <= ptype_d;
            sched.drop <= drop_d;
            if (load) begin
                if (gnt_any) begin
                    sched.cmd_valid  <= 1'b1;
                    sched.cmd_id     <= gnt_id;
                    sched.cmd_repeat <= ptype_q[gnt_id];
                    rr_ptr           <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                end else begin
                    sched.cmd_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench: expected commands are queued with the stimulus and checked at each accept.
module tb_button_cmd_scheduler;
    logic fclk  = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    typedef struct {
        int id;
        int rep;
        int at;
    } exp_t;
    exp_t exp_q[$];

    button_cmd_scheduler_if #(.N_BTN(4)) bus ();

    button_cmd_scheduler #(
        .N_BTN(4),
        .REPEAT_DELAY(4),
        .REPEAT_RATE(2)
    ) dut (
        .fclk (fclk),
        .reset(reset),
        .sched(bus)
    );

    always #5 fclk = ~fclk;
    always @(posedge fclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic expect_cmd(input int id, input int rep, input int at);
        exp_t e;
        e.id  = id;
        e.rep = rep;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    // Accept monitor: a command is accepted at the next rising edge when valid&ready at negedge.
    initial begin
        logic fresh;
        int   load_edge;
        exp_t e;
        fresh     = 1'b1;
        load_edge = 0;
        forever begin
            @(negedge fclk);
            if (bus.cmd_valid && fresh) load_edge = cyc;
            if (bus.cmd_valid && bus.cmd_ready) begin
                check("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("cmd_id", 32'(bus.cmd_id), 32'(e.id));
                    check("cmd_repeat", 32'(bus.cmd_repeat), 32'(e.rep));
                    if (e.at != 0) check("cmd_edge", 32'(load_edge), 32'(e.at));
                end
            end
            fresh = !bus.cmd_valid || bus.cmd_ready;
        end
    end

    initial begin
        int c;
        bus.btn_level = '0;
        bus.cmd_ready = 1'b0;
        #1 reset = 1'b1;
        tick(2);
        check("rst_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_id", 32'(bus.cmd_id), 32'd0);
        check("rst_repeat", 32'(bus.cmd_repeat), 32'd0);
        check("rst_drop", 32'(bus.drop), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        #2 reset = 1'b0;
        tick(3);

        // 1: press then hold-to-repeat on btn0
        c = cyc;
        bus.cmd_ready = 1'b1;
        bus.btn_level = 4'b0001;
        expect_cmd(0, 0, c + 2);
        expect_cmd(0, 1, c + 6);
        expect_cmd(0, 1, c + 8);
        expect_cmd(0, 1, c + 10);
        tick(1);
        check("t1_pend_busy", 32'(bus.busy), 32'd1);
        check("t1_pend_novalid", 32'(bus.cmd_valid), 32'd0);
        tick(1);
        check("t1_first_valid", 32'(bus.cmd_valid), 32'd1);
        tick(8);
        bus.btn_level = 4'b0000;
        tick(4);
        check("t1_idle_valid", 32'(bus.cmd_valid), 32'd0);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: simultaneous btn1/btn3, round-robin order, twice
        for (int r = 0; r < 2; r++) begin
            c = cyc;
            bus.btn_level = 4'b1010;
            expect_cmd(1, 0, c + 2);
            expect_cmd(3, 0, c + 3);
            tick(2);
            bus.btn_level = 4'b0000;
            tick(3);
        end
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: backpressure, stable id, drop on re-press while pending
        bus.cmd_ready = 1'b0;
        bus.btn_level = 4'b0100;
        expect_cmd(2, 0, 0);
        expect_cmd(2, 0, 0);
        tick(2);
        check("t3_valid_a", 32'(bus.cmd_valid), 32'd1);
        check("t3_id_a", 32'(bus.cmd_id), 32'd2);
        tick(1);
        check("t3_id_b", 32'(bus.cmd_id), 32'd2);
        bus.btn_level = 4'b0000;
        tick(1);
        check("t3_valid_c", 32'(bus.cmd_valid), 32'd1);
        check("t3_id_c", 32'(bus.cmd_id), 32'd2);
        bus.btn_level = 4'b0100;
        tick(1);
        check("t3_no_drop", 32'(bus.drop), 32'd0);
        bus.btn_level = 4'b0000;
        tick(1);
        bus.btn_level = 4'b0100;
        tick(1);
        check("t3_drop_pulse", 32'(bus.drop), 32'd1);
        bus.btn_level = 4'b0000;
        tick(1);
        check("t3_drop_clear", 32'(bus.drop), 32'd0);
        check("t3_id_d", 32'(bus.cmd_id), 32'd2);
        bus.cmd_ready = 1'b1;
        tick(4);
        check("t3_done_valid", 32'(bus.cmd_valid), 32'd0);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: pending repeat is discarded on release, press cmd survives
        bus.cmd_ready = 1'b0;
        bus.btn_level = 4'b0001;
        expect_cmd(0, 0, 0);
        tick(5);
        check("t4_held_valid", 32'(bus.cmd_valid), 32'd1);
        check("t4_held_repeat", 32'(bus.cmd_repeat), 32'd0);
        bus.btn_level = 4'b0000;
        tick(1);
        bus.cmd_ready = 1'b1;
        tick(4);
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset with a command in flight
        bus.cmd_ready = 1'b0;
        bus.btn_level = 4'b0010;
        tick(5);
        check("t5_pre_valid", 32'(bus.cmd_valid), 32'd1);
        check("t5_pre_id", 32'(bus.cmd_id), 32'd1);
        reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(bus.cmd_valid), 32'd0);
        check("t5_async_id", 32'(bus.cmd_id), 32'd0);
        check("t5_async_busy", 32'(bus.busy), 32'd0);
        tick(1);
        bus.cmd_ready = 1'b1;
        #2 reset = 1'b0;
        c = cyc;
        expect_cmd(1, 0, c + 2);
        tick(2);
        bus.btn_level = 4'b0000;
        tick(4);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: release coincides with the first-repeat terminal count
        c = cyc;
        bus.btn_level = 4'b1000;
        expect_cmd(3, 0, c + 2);
        tick(4);
        bus.btn_level = 4'b0000;
        tick(6);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        c = cyc;
        bus.btn_level = 4'b1000;
        expect_cmd(3, 0, c + 2);
        tick(2);
        bus.btn_level = 4'b0000;
        tick(4);
        check("t6_repress_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
